// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared core constants for decode and the pc sequencer
// Purpose: branch condition encodings, sequencer FSM state encoding, and the
//          branch-taken evaluation shared by decode and the sequencer.
// Ports:   none (package).
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BRANCH_NEVER        = 2'b00,
    BRANCH_ALU_NON_ZERO = 2'b01,
    BRANCH_ALU_ZERO     = 2'b10,
    BRANCH_ALWAYS       = 2'b11
  } branch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic branch_taken(input branch_op_e op, input logic alu_zero);
    logic taken;
    case (op)
      BRANCH_NEVER:        taken = 1'b0;
      BRANCH_ALU_NON_ZERO: taken = ~alu_zero;
      BRANCH_ALU_ZERO:     taken = alu_zero;
      BRANCH_ALWAYS:       taken = 1'b1;
      default:             taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory fetch bus
// Purpose: groups the fetch request/response handshake.
// Signals: imem_req (fetch request), imem_addr (fetch address),
//          imem_ready (fetch data valid this cycle), imem_rdata (instruction word).
// Modports: master = sequencer side, slave = instruction memory side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer_next_pc_unit.sv
// rtl/pc_sequencer_next_pc_unit.sv - combinational branch resolution and next-pc select
// Purpose: evaluates the branch condition and selects pc+4 or the effective target.
// Ports:   pc, branch_op, alu_zero, branch_target (in);
//          next_pc, fault (out; fault = taken branch to a target with bit 1 set).
module next_pc_unit
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        fault
);

  logic        taken;
  logic [31:0] eff_target;

  assign taken      = branch_taken(branch_op_e'(branch_op), alu_zero);
  // Bit 0 of the target is always dropped; bit 1 set means a half-word target.
  assign eff_target = branch_target & 32'hFFFF_FFFE;
  assign next_pc    = taken ? eff_target : (pc + INSTR_BYTES);
  assign fault      = taken & branch_target[1];

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer: fetch, issue, retire, halt on fault
// Purpose: fetches the instruction at pc, holds it for execute, then advances pc
//          to pc+4 or the branch target; a taken misaligned branch halts the core.
// Ports:   clk, reset_n (async active-low); imem (fetch bus master);
//          instr/instr_valid (to decode); exec_done, branch_op, alu_zero,
//          branch_target (from execute); pc, instret, misalign_err (status).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  pc_sequencer_if.master     imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic [1:0]         branch_op,
  input  logic               alu_zero,
  input  logic [31:0]        branch_target,
  output logic [31:0]        pc,
  output logic [31:0]        instret,
  output logic               misalign_err
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        misalign_err_q, misalign_err_d;

  logic [31:0] next_pc;
  logic        fault;

  next_pc_unit u_next_pc (
    .pc            (pc_q),
    .branch_op     (branch_op),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .fault         (fault)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= 32'h0;
      instret_q      <= 32'h0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instret_q      <= instret_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instret_d      = instret_q;
    misalign_err_d = misalign_err_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (exec_done) begin
          if (fault) begin
            // Leave pc pointing at the faulting branch for post-mortem.
            misalign_err_d = 1'b1;
            state_d        = ST_HALT;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the state register so they drop to 0 the moment reset asserts.
  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ST_ISSUE);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign instret        = instret_q;
  assign misalign_err   = misalign_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exec_done;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  pc_sequencer_if imem_bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem          (imem_bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_op     (branch_op),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .pc            (pc),
    .instret       (instret),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word;
    tick();
    imem_bus.imem_ready = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic z, input logic [31:0] tgt);
    exec_done     = 1'b1;
    branch_op     = op;
    alu_zero      = z;
    branch_target = tgt;
    tick();
    exec_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h want 0", instret); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_bus.imem_req); end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr: got %h want %h", imem_bus.imem_addr, 32'h100); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_bus.imem_addr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_bus.imem_addr, 32'h100 + 32'(4 * i)); end
      fetch(32'hA000_0000 + 32'(i));
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, instr_valid); end
      checks++; if (instr !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, 32'hA000_0000 + 32'(i)); end
      issue(2'b00, 1'b0, 32'h0);
    end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret: got %0d want 3", instret); end
    checks++; if (imem_bus.imem_addr !== 32'h10C) begin errors++; $display("FAIL seq_next_addr: got %h want %h", imem_bus.imem_addr, 32'h10C); end
  endtask

  task automatic test_branch_cond();
    fetch(32'h1); issue(2'b11, 1'b0, 32'h200);
    checks++; if (imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL br_always: got %h want %h", imem_bus.imem_addr, 32'h200); end
    fetch(32'h2); issue(2'b10, 1'b1, 32'h180);
    checks++; if (imem_bus.imem_addr !== 32'h180) begin errors++; $display("FAIL br_zero_taken: got %h want %h", imem_bus.imem_addr, 32'h180); end
    fetch(32'h3); issue(2'b11, 1'b0, 32'h200);
    fetch(32'h4); issue(2'b10, 1'b0, 32'h180);
    checks++; if (imem_bus.imem_addr !== 32'h204) begin errors++; $display("FAIL br_zero_not_taken: got %h want %h", imem_bus.imem_addr, 32'h204); end
    fetch(32'h5); issue(2'b01, 1'b0, 32'h400);
    checks++; if (imem_bus.imem_addr !== 32'h400) begin errors++; $display("FAIL br_nz_taken: got %h want %h", imem_bus.imem_addr, 32'h400); end
    fetch(32'h6); issue(2'b01, 1'b1, 32'h500);
    checks++; if (imem_bus.imem_addr !== 32'h404) begin errors++; $display("FAIL br_nz_not_taken: got %h want %h", imem_bus.imem_addr, 32'h404); end
    checks++; if (instret !== 32'd9) begin errors++; $display("FAIL br_instret: got %0d want 9", instret); end
  endtask

  task automatic test_stall();
    imem_bus.imem_ready = 1'b0;
    exec_done = 1'b1;
    branch_op = 2'b11;
    branch_target = 32'h800;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_req%0d: got %b want 1", i, imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== 32'h404) begin errors++; $display("FAIL stall_addr%0d: got %h want %h", i, imem_bus.imem_addr, 32'h404); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b want 0", i, instr_valid); end
    end
    exec_done = 1'b0;
    fetch(32'hDEAD_BEEF);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b want 1", i, instr_valid); end
      checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_instr%0d: got %h want %h", i, instr, 32'hDEAD_BEEF); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d: got %b want 0", i, imem_bus.imem_req); end
    end
    imem_bus.imem_ready = 1'b0;
    issue(2'b00, 1'b0, 32'h0);
    checks++; if (imem_bus.imem_addr !== 32'h408) begin errors++; $display("FAIL stall_resume: got %h want %h", imem_bus.imem_addr, 32'h408); end
  endtask

  task automatic test_wrap();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want %h", instret, 32'hFFFF_FFFF); end
    fetch(32'h7); issue(2'b11, 1'b0, 32'hFFFF_FFFC);
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL instret_wrap: got %h want 0", instret); end
    checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr: got %h want %h", imem_bus.imem_addr, 32'hFFFF_FFFC); end
    fetch(32'h8); issue(2'b10, 1'b0, 32'h600);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", pc); end
    checks++; if (instret !== 32'h1) begin errors++; $display("FAIL wrap_instret_after: got %h want 1", instret); end
  endtask

  task automatic test_reset_mid_issue();
    fetch(32'h9);
    exec_done = 1'b1;
    branch_op = 2'b11;
    branch_target = 32'h400;
    reset_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL async_pc: got %h want %h", pc, 32'h100); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", instr_valid); end
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mid_issue_pc: got %h want %h", pc, 32'h100); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL mid_issue_instret: got %h want 0", instret); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_issue_instr: got %h want 0", instr); end
    exec_done = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rerun_req: got %b want 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rerun_addr: got %h want %h", imem_bus.imem_addr, 32'h100); end
  endtask

  task automatic test_misalign();
    fetch(32'hA); issue(2'b11, 1'b0, 32'h0000_0301);
    checks++; if (imem_bus.imem_addr !== 32'h300) begin errors++; $display("FAIL bit0_clear: got %h want %h", imem_bus.imem_addr, 32'h300); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL bit0_no_fault: got %b want 0", misalign_err); end
    fetch(32'hB); issue(2'b11, 1'b0, 32'h0000_0302);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b want 1", misalign_err); end
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL misalign_pc: got %h want %h", pc, 32'h300); end
    checks++; if (instret !== 32'h1) begin errors++; $display("FAIL misalign_instret: got %h want 1", instret); end
    imem_bus.imem_ready = 1'b1;
    exec_done = 1'b1;
    branch_op = 2'b00;
    for (int i = 0; i < 10; i++) begin
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req%0d: got %b want 0", i, imem_bus.imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid%0d: got %b want 0", i, instr_valid); end
      tick();
    end
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL halt_pc: got %h want %h", pc, 32'h300); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", misalign_err); end
    imem_bus.imem_ready = 1'b0;
    exec_done = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    exec_done           = 1'b0;
    branch_op           = 2'b00;
    alu_zero            = 1'b0;
    branch_target       = 32'h0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    test_reset();
    test_back_to_back();
    test_branch_cond();
    test_stall();
    test_wrap();
    test_reset_mid_issue();
    test_misalign();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_addr  output  32  fetch address, equal to pc.
REQ-006 imem_ready  input  1  fetch data valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  latched instruction presented to decode.
REQ-009 instr_valid  output  1  instr is valid and awaiting execution.
REQ-010 exec_done  input  1  execute stage has finished instr; branch inputs are valid this cycle.
REQ-011 branch_op  input  2  00 never, 01 ALU non-zero, 10 ALU zero, 11 always.
REQ-012 alu_zero  input  1  ALU result was zero.
REQ-013 branch_target  input  32  computed base+offset target.
REQ-014 pc  output  32  address of the current instruction.
REQ-015 instret  output  32  count of retired instructions.
REQ-016 misalign_err  output  1  sticky fault flag for a taken, misaligned target.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, ISSUE and HALT.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-020 In FETCH, on imem_ready=1 the block SHALL latch imem_rdata into instr and go to ISSUE at the same edge.
REQ-021 In FETCH, while imem_ready=0 the block SHALL hold FETCH with imem_req asserted, with no timeout.
REQ-022 imem_req SHALL be 0 in every state other than FETCH.
REQ-023 instr_valid SHALL be 1 only in ISSUE, and instr SHALL be stable while in ISSUE.
REQ-024 exec_done SHALL be ignored outside ISSUE, and imem_ready SHALL be ignored outside FETCH.
REQ-025 taken SHALL equal: 0 for op 00; !alu_zero for op 01; alu_zero for op 10; 1 for op 11.
REQ-026 The effective target SHALL be {branch_target[31:1],1'b0}, i.e. bit 0 is cleared.
REQ-027 In ISSUE with exec_done=1, taken=1 and branch_target[1]=0, the block SHALL load pc with the effective target, increment instret, and go to FETCH at that edge.
REQ-028 In ISSUE with exec_done=1 and taken=0, the block SHALL load pc with pc+4 (modulo 2^32, wrapping), increment instret, and go to FETCH.
REQ-029 In ISSUE with exec_done=1, taken=1 and branch_target[1]=1, the block SHALL keep pc unchanged, leave instret unchanged, set misalign_err=1, and go to HALT.
REQ-030 HALT SHALL be left only by reset, with imem_req=0 and instr_valid=0 while in HALT.
REQ-031 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-032 Minimum loop latency SHALL be 2 cycles per instruction (FETCH with immediate ready, then ISSUE with immediate exec_done).

Reset
REQ-033 On reset_n=0 the block SHALL, asynchronously, set state=IDLE, pc=RESET_PC, instr=0, instret=0, misalign_err=0, imem_req=0 and instr_valid=0.
REQ-034 Reset asserted mid-fetch or mid-issue SHALL abandon the operation, and imem_rdata and exec_done arriving in that cycle SHALL have no effect.
REQ-035 After reset_n deasserts, the first imem_req SHALL assert in the second rising edge's cycle (IDLE then FETCH).

Structure
REQ-036 The BRANCH_* encodings (NEVER/ALU_NON_ZERO/ALU_ZERO/ALWAYS) and the FSM state encoding SHALL reside in a shared core constants package used by decode and this block.
REQ-037 Taken evaluation plus next-PC selection SHALL be a combinational sub-module, next_pc_unit, with inputs pc, branch_op, alu_zero and branch_target, and outputs next_pc and fault.
REQ-038 The FSM, pc, instr and instret registers SHALL reside in pc_sequencer.

Verification
REQ-039 Reset with RESET_PC=32'h100, imem_ready=1, exec_done=1 and branch_op=00 -> imem_addr sequence 100,104,108, with instret reaching 3 after three ISSUE cycles.
REQ-040 pc=32'h200, branch_op=10, alu_zero=1, branch_target=32'h180 -> next imem_addr=32'h180; the same with alu_zero=0 -> 32'h204.
REQ-041 branch_op=11, branch_target=32'h0000_0301 -> pc=32'h300; branch_target=32'h302 -> misalign_err=1, HALT, imem_req held 0 for 10 cycles.
REQ-042 imem_ready held 0 for 5 cycles -> imem_req and imem_addr held constant, and instr_valid=0 throughout.
REQ-043 pc=32'hFFFF_FFFC with a not-taken branch -> pc=32'h0; instret preloaded to 32'hFFFF_FFFF (force) and then incremented -> 0.
REQ-044 reset_n pulsed low during ISSUE with exec_done=1 -> pc=RESET_PC, instret=0, and no pc update from that cycle.
